dmem_arbiter: RTL
=================

# dmem_arbiter

Arbiter that shares the single data-memory port between the pipeline MEM stage and an external loader/debug requester. The CPU has priority. A starvation counter forces an external grant after a bounded wait, and the arbiter stalls the pipeline during that cycle. It sits between the MEM-stage controls (address, write data, memRead, memWrite) and the data memory, and feeds a stall into the hazard-detection path.

## Interface
- DW, 16, data width
- AW, 16, address width
- STARVE_MAX, 4, consecutive denied cycles before the external requester is forced through (range 1..15)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- cpu_rd  in  1  MEM-stage read request
- cpu_wr  in  1  MEM-stage write request
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  read data, combinational, valid in the CPU-grant cycle
- cpu_stall  out  1  CPU access denied this cycle; pipeline holds MEM and earlier stages
- ext_req  in  1  external access request, held until granted
- ext_we  in  1  1 = write, 0 = read
- ext_addr  in  AW  external address
- ext_wdata  in  DW  external write data
- ext_gnt  out  1  external access performed this cycle
- ext_rvalid  out  1  registered read data valid
- ext_rdata  out  DW  registered read data
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_rdata  in  DW  memory read data (combinational read)
- arb_err  out  1  sticky: cpu_rd and cpu_wr were asserted together

## Operation
- cpu_acc = cpu_rd | cpu_wr.
- ext_gnt = ext_req & (~cpu_acc | starve_cnt == STARVE_MAX).
- cpu_gnt = cpu_acc & ~ext_gnt.
- cpu_stall = cpu_acc & ext_gnt.
- Memory mux:
  - ext_gnt: ext_addr, ext_wdata, read = ~ext_we, write = ext_we.
  - cpu_gnt: CPU signals. If cpu_rd & cpu_wr, the access is a write and arb_err is set.
  - Neither: strobes 0, addr/wdata 0.
- Exactly one strobe is high, or none, in every cycle.
- cpu_rdata = mem_rdata when cpu_gnt & cpu_rd, else 0.
- starve_cnt (4-bit): next = min(starve_cnt+1, STARVE_MAX) if ext_req & ~ext_gnt; otherwise 0.
- FSM state records the previous cycle's owner:
  - ARB_IDLE: no access
  - ARB_CPU: cpu_gnt
  - ARB_EXT_RD: ext_gnt & ~ext_we
  - ARB_EXT_WR: ext_gnt & ext_we
  - Next state is decided from the current grant. All transitions are legal every cycle.
- ext_rvalid = (state == ARB_EXT_RD). ext_rdata is the mem_rdata captured at the grant edge and held until the next external read.
- Back-to-back external grants are allowed when the CPU is idle. Each read yields one rvalid pulse.
- Writes produce no response.

## Timing
- Grant and stall are same-cycle combinational. A CPU access completes in its grant cycle.
- External read latency: grant in cycle t, ext_rvalid/ext_rdata in cycle t+1.
- Worst-case external wait with continuous CPU traffic: STARVE_MAX cycles, granted in cycle STARVE_MAX after the request was first seen.
- The stall lasts exactly one cycle per forced grant. starve_cnt then clears, so the CPU always wins the next cycle.
- Reset (asynchronous assert, synchronous-safe release) sets state ARB_IDLE, starve_cnt 0, ext_rvalid 0, ext_rdata 0, arb_err 0. Combinational outputs follow the inputs.
- Reset mid-read drops the pending rvalid.
- ext_req deasserted before grant clears starve_cnt.

## Configuration
- DMEM_ARB_FAIR_EN defined: starvation counter present, behaviour as above.
- Not defined: strict CPU priority. ext_gnt = ext_req & ~cpu_acc, cpu_stall is tied 0, and there is no counter logic.

## Structure
- Shared package cpu_pkg holds DW/AW defaults, STARVE_MAX default, and the arb_state_t enum (ARB_IDLE, ARB_CPU, ARB_EXT_RD, ARB_EXT_WR).
- One sub-module, starve_ctr: saturating counter with inc/clr inputs and an at_max output. It is instantiated only under DMEM_ARB_FAIR_EN.

## Test plan
- Reset then idle → all strobes 0, ext_rvalid 0, arb_err 0, cpu_stall 0.
- CPU idle, external read addr 0x0010 with memory holding 0xBEEF → ext_gnt same cycle, ext_rvalid=1 and ext_rdata=0xBEEF next cycle.
- CPU reads every cycle while ext_req is held (STARVE_MAX=4) → CPU granted cycles 0–3, ext_gnt and cpu_stall in cycle 4, CPU granted cycle 5. Without the macro, the external requester is never granted.
- CPU write 0x1234 to 0x0020 and external write pending with counter below max → memory written with CPU data only, ext_gnt 0, starve_cnt increments.
- cpu_rd=cpu_wr=1 → write performed, arb_err=1 and stays 1 until rst low.
- rst asserted in the cycle after an external read grant → ext_rvalid forced 0 immediately, state ARB_IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width defaults and the data-memory arbiter owner encoding.
package cpu_pkg;

  localparam int unsigned DW_DEF         = 16;
  localparam int unsigned AW_DEF         = 16;
  localparam int unsigned STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_CPU    = 2'd1,
    ARB_EXT_RD = 2'd2,
    ARB_EXT_WR = 2'd3
  } arb_state_t;

endpackage

// File: rtl/starve_ctr.sv
// Saturating 4-bit wait counter for the external requester; clr wins over inc.
module starve_ctr #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [3:0] MAX4 = 4'(MAX);

  logic [3:0] cnt;

  assign at_max = (cnt == MAX4);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: MEM stage has priority over the external loader/debug port.
// DMEM_ARB_FAIR_EN enables the starvation counter that forces an external grant and stalls the CPU.
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata,
  output logic          arb_err
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("dmem_arbiter: STARVE_MAX must be within 1..15");
  end

  arb_state_t state, state_nxt;
  logic       cpu_acc;
  logic       cpu_gnt;

  assign cpu_acc = cpu_rd | cpu_wr;
  assign cpu_gnt = cpu_acc & ~ext_gnt;

`ifdef DMEM_ARB_FAIR_EN
  logic at_max;
  logic ctr_inc;
  logic ctr_clr;

  // Any cycle the external port is not kept waiting restarts the count.
  assign ctr_inc = ext_req & ~ext_gnt;
  assign ctr_clr = ~ctr_inc;

  starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk    (clk),
    .rst    (rst),
    .inc    (ctr_inc),
    .clr    (ctr_clr),
    .at_max (at_max)
  );

  assign ext_gnt   = ext_req & (~cpu_acc | at_max);
  assign cpu_stall = cpu_acc & ext_gnt;
`else
  assign ext_gnt   = ext_req & ~cpu_acc;
  assign cpu_stall = 1'b0;
`endif

  // Memory port mux; a simultaneous CPU read+write is carried out as a write.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    cpu_rdata = '0;
    if (ext_gnt) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_read  = ~ext_we;
      mem_write = ext_we;
    end else if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_read  = cpu_rd & ~cpu_wr;
      mem_write = cpu_wr;
      if (cpu_rd) begin
        cpu_rdata = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = ARB_IDLE;
    if (ext_gnt) begin
      state_nxt = ext_we ? ARB_EXT_WR : ARB_EXT_RD;
    end else if (cpu_gnt) begin
      state_nxt = ARB_CPU;
    end
  end

  always_comb begin
    ext_rvalid = (state == ARB_EXT_RD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_rdata <= '0;
    end else if (ext_gnt && !ext_we) begin
      ext_rdata <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arb_err <= 1'b0;
    end else if (cpu_rd && cpu_wr) begin
      arb_err <= 1'b1;
    end
  end

endmodule
